// File: rtl/tls_pkg.sv
// Shared lamp encodings, fault codes and lamp-rule helpers for the traffic-light monitor.
package tls_pkg;

    localparam logic [2:0] L_G = 3'b100;
    localparam logic [2:0] L_Y = 3'b010;
    localparam logic [2:0] L_R = 3'b001;

    typedef enum logic [2:0] {
        F_NONE     = 3'd0,
        F_BAD_ENC  = 3'd1,
        F_CONFLICT = 3'd2,
        F_BAD_SEQ  = 3'd3,
        F_OVERRUN  = 3'd4
    } fault_e;

    function automatic logic lamp_valid(input logic [2:0] lamp);
        return (lamp == L_G) || (lamp == L_Y) || (lamp == L_R);
    endfunction

    // A road may hold its lamp or advance one step around G -> Y -> R -> G.
    function automatic logic legal_step(input logic [2:0] prev, input logic [2:0] cur);
        return (prev == cur) ||
               ((prev == L_G) && (cur == L_Y)) ||
               ((prev == L_Y) && (cur == L_R)) ||
               ((prev == L_R) && (cur == L_G));
    endfunction

endpackage

// File: rtl/tls_road_tracker.sv
// Per-road observer: encoding and phase-order checks plus green-phase length measurement.
module tls_road_tracker
    import tls_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    lamp,
    output logic          bad_enc,
    output logic          bad_seq,
    output logic          overrun,
    output logic [CW-1:0] len,
    output logic          len_valid
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [2:0]    prev;
    logic [CW-1:0] cnt;

    // An invalid previous sample gives no reference, so only valid-to-valid steps are judged.
    assign bad_enc = !lamp_valid(lamp);
    assign bad_seq = lamp_valid(lamp) && lamp_valid(prev) && !legal_step(prev, lamp);
    assign overrun = (lamp == L_G) && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev      <= L_R;
            cnt       <= '0;
            len       <= '0;
            len_valid <= 1'b0;
        end else begin
            prev      <= lamp;
            len_valid <= 1'b0;
            if (lamp == L_G) begin
                if (prev != L_G)
                    cnt <= CW'(1);
                else if (cnt != CNT_MAX)
                    cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
                // Only a proper amber exit counts as a completed green phase.
                if ((lamp == L_Y) && (prev == L_G)) begin
                    len       <= cnt;
                    len_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tls_monitor.sv
// Passive two-road traffic-light monitor: conflict check, fault priority and sticky fault latch.
module tls_monitor
    import tls_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    LA,
    input  logic [2:0]    LB,
    input  logic          clr_fault,
    output logic          fault,
    output logic [2:0]    fault_code,
    output logic [CW-1:0] green_a_len,
    output logic [CW-1:0] green_b_len,
    output logic          len_valid_a,
    output logic          len_valid_b
);

    logic   enc_a, enc_b, seq_a, seq_b, ovr_a, ovr_b;
    logic   conflict;
    fault_e new_code;

    tls_road_tracker #(.CW(CW)) u_road_a (
        .clk       (clk),
        .rst       (rst),
        .lamp      (LA),
        .bad_enc   (enc_a),
        .bad_seq   (seq_a),
        .overrun   (ovr_a),
        .len       (green_a_len),
        .len_valid (len_valid_a)
    );

    tls_road_tracker #(.CW(CW)) u_road_b (
        .clk       (clk),
        .rst       (rst),
        .lamp      (LB),
        .bad_enc   (enc_b),
        .bad_seq   (seq_b),
        .overrun   (ovr_b),
        .len       (green_b_len),
        .len_valid (len_valid_b)
    );

    assign conflict = (LA != L_R) && (LB != L_R);

    always_comb begin
        new_code = F_NONE;
        if (enc_a || enc_b)
            new_code = F_BAD_ENC;
        else if (conflict)
            new_code = F_CONFLICT;
        else if (seq_a || seq_b)
            new_code = F_BAD_SEQ;
        else if (ovr_a || ovr_b)
            new_code = F_OVERRUN;
    end

    // A fresh fault on a clearing edge wins over the clear; otherwise the first fault sticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault      <= 1'b0;
            fault_code <= F_NONE;
        end else if ((new_code != F_NONE) && (!fault || clr_fault)) begin
            fault      <= 1'b1;
            fault_code <= new_code;
        end else if (clr_fault) begin
            fault      <= 1'b0;
            fault_code <= F_NONE;
        end
    end

endmodule

// File: tb/tb_tls_monitor.sv
// Self-checking bench for tls_monitor: directed scenarios plus a randomized lamp walk against a rule model.
module tb_tls_monitor;
    import tls_pkg::*;

    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [2:0]    la = L_R;
    logic [2:0]    lb = L_R;
    logic          clr_fault = 1'b0;
    logic          fault;
    logic [2:0]    fault_code;
    logic [CW-1:0] green_a_len, green_b_len;
    logic          len_valid_a, len_valid_b;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [2:0] m_prev [2];
    int         m_cnt  [2];
    int         m_len  [2];
    bit         m_valid[2];
    bit         m_fault;
    int         m_code;

    tls_monitor #(.CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .LA          (la),
        .LB          (lb),
        .clr_fault   (clr_fault),
        .fault       (fault),
        .fault_code  (fault_code),
        .green_a_len (green_a_len),
        .green_b_len (green_b_len),
        .len_valid_a (len_valid_a),
        .len_valid_b (len_valid_b)
    );

    always #5 clk = ~clk;

    function automatic bit is_lamp(input logic [2:0] v);
        return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
    endfunction

    // The lamp cycle as an ordered ring; a legal step holds or moves one place along it.
    function automatic logic [2:0] next_of(input logic [2:0] v);
        logic [2:0] ring [3];
        ring[0] = 3'b100; ring[1] = 3'b010; ring[2] = 3'b001;
        for (int i = 0; i < 3; i++)
            if (ring[i] == v) return ring[(i + 1) % 3];
        return 3'b001;
    endfunction

    function automatic logic [21:0] dut_vec();
        return {fault, fault_code, green_a_len, green_b_len, len_valid_a, len_valid_b};
    endfunction

    function automatic logic [21:0] model_vec();
        return {m_fault, 3'(m_code), 8'(m_len[0]), 8'(m_len[1]), m_valid[0], m_valid[1]};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            m_prev[r] = 3'b001; m_cnt[r] = 0; m_len[r] = 0; m_valid[r] = 0;
        end
        m_fault = 0; m_code = 0;
    endtask

    task automatic model_step(input logic [2:0] a, input logic [2:0] b, input bit clr);
        logic [2:0] cur [2];
        bit enc = 0, seq = 0, ovr = 0, conf;
        int code;
        cur[0] = a; cur[1] = b;
        for (int r = 0; r < 2; r++) begin
            if (!is_lamp(cur[r])) enc = 1;
            else if (is_lamp(m_prev[r]) && cur[r] != m_prev[r] && cur[r] != next_of(m_prev[r])) seq = 1;
            if (cur[r] == 3'b100 && m_cnt[r] == CMAX) ovr = 1;
        end
        conf = (a != 3'b001) && (b != 3'b001);
        code = enc ? 1 : conf ? 2 : seq ? 3 : ovr ? 4 : 0;
        if (code != 0 && (!m_fault || clr)) begin
            m_fault = 1; m_code = code;
        end else if (clr) begin
            m_fault = 0; m_code = 0;
        end
        for (int r = 0; r < 2; r++) begin
            m_valid[r] = 0;
            if (cur[r] == 3'b100)
                m_cnt[r] = (m_prev[r] == 3'b100) ? ((m_cnt[r] < CMAX) ? m_cnt[r] + 1 : CMAX) : 1;
            else begin
                if (cur[r] == 3'b010 && m_prev[r] == 3'b100) begin
                    m_len[r] = m_cnt[r]; m_valid[r] = 1;
                end
                m_cnt[r] = 0;
            end
            m_prev[r] = cur[r];
        end
    endtask

    task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b, input bit clr);
        la = a; lb = b; clr_fault = clr;
        @(posedge clk);
        model_step(a, b, clr);
        #1;
    endtask

    task automatic do_reset();
        la = L_R; lb = L_R; clr_fault = 0; rst = 0;
        @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_compared++;
        if (dut_vec() !== 22'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_state: got %h want 000000", dut_vec());
        end
    endtask

    task automatic test_legal_cycle();
        do_reset();
        for (int i = 0; i < 5; i++) applyStimulus(L_R, L_G, 0);
        applyStimulus(L_R, L_Y, 0);
        n_compared++;
        if ({len_valid_b, green_b_len} !== {1'b1, 8'd5}) begin
            n_mismatched++;
            $display("[TB] FAIL legal_len_b: got v=%0b len=%0d want v=1 len=5", len_valid_b, green_b_len);
        end
        applyStimulus(L_R, L_Y, 0);
        n_compared++;
        if (len_valid_b !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL legal_pulse_b: got %0b want 0", len_valid_b);
        end
        applyStimulus(L_R, L_R, 0);
        for (int i = 0; i < 7; i++) applyStimulus(L_G, L_R, 0);
        applyStimulus(L_Y, L_R, 0);
        n_compared++;
        if ({len_valid_a, green_a_len, fault} !== {1'b1, 8'd7, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL legal_len_a: got v=%0b len=%0d f=%0b want v=1 len=7 f=0", len_valid_a, green_a_len, fault);
        end
        applyStimulus(L_Y, L_R, 0);
        n_compared++;
        if (dut_vec() !== model_vec()) begin
            n_mismatched++;
            $display("[TB] FAIL legal_end: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_enc_conflict();
        do_reset();
        applyStimulus(3'b110, L_R, 0);
        n_compared++;
        if ({fault, fault_code} !== {1'b1, 3'd1}) begin
            n_mismatched++;
            $display("[TB] FAIL bad_enc: got f=%0b code=%0d want f=1 code=1", fault, fault_code);
        end
        applyStimulus(L_R, L_R, 1);
        n_compared++;
        if ({fault, fault_code} !== {1'b0, 3'd0}) begin
            n_mismatched++;
            $display("[TB] FAIL enc_clear: got f=%0b code=%0d want f=0 code=0", fault, fault_code);
        end
        applyStimulus(L_G, L_G, 0);
        n_compared++;
        if ({fault, fault_code} !== {1'b1, 3'd2}) begin
            n_mismatched++;
            $display("[TB] FAIL conflict: got f=%0b code=%0d want f=1 code=2", fault, fault_code);
        end
    endtask

    task automatic test_sequence();
        do_reset();
        for (int i = 0; i < 3; i++) applyStimulus(L_G, L_R, 0);
        applyStimulus(L_R, L_R, 0);
        n_compared++;
        if ({fault, fault_code, len_valid_a, green_a_len} !== {1'b1, 3'd3, 1'b0, 8'd0}) begin
            n_mismatched++;
            $display("[TB] FAIL seq_g_to_r: got f=%0b code=%0d v=%0b len=%0d want f=1 code=3 v=0 len=0",
                     fault, fault_code, len_valid_a, green_a_len);
        end
        do_reset();
        applyStimulus(L_G, L_R, 0);
        applyStimulus(L_Y, L_R, 0);
        applyStimulus(L_G, L_R, 0);
        n_compared++;
        if ({fault, fault_code} !== {1'b1, 3'd3}) begin
            n_mismatched++;
            $display("[TB] FAIL seq_y_to_g: got f=%0b code=%0d want f=1 code=3", fault, fault_code);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        for (int i = 0; i < 255; i++) applyStimulus(L_G, L_R, 0);
        n_compared++;
        if (fault !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL overrun_early: got f=%0b want 0", fault);
        end
        applyStimulus(L_G, L_R, 0);
        n_compared++;
        if ({fault, fault_code} !== {1'b1, 3'd4}) begin
            n_mismatched++;
            $display("[TB] FAIL overrun: got f=%0b code=%0d want f=1 code=4", fault, fault_code);
        end
        applyStimulus(L_Y, L_R, 0);
        n_compared++;
        if ({len_valid_a, green_a_len} !== {1'b1, 8'd255}) begin
            n_mismatched++;
            $display("[TB] FAIL overrun_len: got v=%0b len=%0d want v=1 len=255", len_valid_a, green_a_len);
        end
    endtask

    task automatic test_precedence();
        do_reset();
        applyStimulus(L_G, L_R, 0);
        applyStimulus(L_R, L_R, 0);
        applyStimulus(L_G, L_G, 0);
        n_compared++;
        if ({fault, fault_code} !== {1'b1, 3'd3}) begin
            n_mismatched++;
            $display("[TB] FAIL sticky_code: got f=%0b code=%0d want f=1 code=3", fault, fault_code);
        end
        applyStimulus(L_Y, L_Y, 0);
        applyStimulus(L_R, L_R, 0);
        applyStimulus(L_R, L_R, 1);
        n_compared++;
        if ({fault, fault_code} !== {1'b0, 3'd0}) begin
            n_mismatched++;
            $display("[TB] FAIL clean_clear: got f=%0b code=%0d want f=0 code=0", fault, fault_code);
        end
        applyStimulus(L_G, L_R, 0);
        applyStimulus(L_R, L_R, 0);
        applyStimulus(L_G, L_G, 1);
        n_compared++;
        if ({fault, fault_code} !== {1'b1, 3'd2}) begin
            n_mismatched++;
            $display("[TB] FAIL clear_vs_fault: got f=%0b code=%0d want f=1 code=2", fault, fault_code);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        applyStimulus(L_G, L_R, 0);
        applyStimulus(L_G, L_R, 0);
        applyStimulus(L_Y, L_R, 0);
        applyStimulus(L_R, L_G, 0);
        applyStimulus(3'b111, L_G, 0);
        #2;
        rst = 0;
        #1;
        model_reset();
        n_compared++;
        if (dut_vec() !== 22'd0) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset: got %h want 000000", dut_vec());
        end
        la = L_G; lb = L_R;
        @(negedge clk);
        rst = 1;
        applyStimulus(L_G, L_R, 0);
        applyStimulus(L_Y, L_R, 0);
        n_compared++;
        if ({fault, len_valid_a, green_a_len} !== {1'b0, 1'b1, 8'd1}) begin
            n_mismatched++;
            $display("[TB] FAIL post_reset_len: got f=%0b v=%0b len=%0d want f=0 v=1 len=1",
                     fault, len_valid_a, green_a_len);
        end
    endtask

    task automatic test_random();
        logic [2:0] a, b;
        int pick;
        do_reset();
        a = L_R; b = L_R;
        for (int i = 0; i < 400; i++) begin
            pick = $urandom_range(0, 19);
            if (pick < 13) a = ($urandom_range(0, 2) == 0) ? next_of(a) : a;
            else if (pick < 19) b = ($urandom_range(0, 2) == 0) ? next_of(b) : b;
            else if ($urandom_range(0, 1) == 0) a = 3'($urandom_range(0, 7));
            else b = 3'($urandom_range(0, 7));
            if (!is_lamp(a)) a = is_lamp(a) ? a : ((i % 2) ? a : L_R);
            applyStimulus(a, b, $urandom_range(0, 4) == 0);
            n_compared++;
            if (dut_vec() !== model_vec()) begin
                n_mismatched++;
                $display("[TB] FAIL random_step%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_legal_cycle();
        test_enc_conflict();
        test_sequence();
        test_overrun();
        test_precedence();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
